branch_resolve_queue: RTL and testbench

- Sits between fetch and execute. Fetch records every predictor lookup result (PC, predicted direction, predicted target) in an in-order queue.
- Execute resolves entries in order. On a misprediction the block drives the predictor's update port (miss, BranchTaken, WriteAddr, WriteTarget), redirects fetch and flushes the queue.
- It is the write-side counterpart of the branch target/2-bit predictor.

---
 rtl/branch_resolve_queue_pkg.sv | 25 ++
 rtl/branch_resolve_queue_fifo.sv | 55 +++++
 rtl/branch_resolve_queue.sv | 124 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: the queued prediction record,
// the FSM state and the fall-through step sizes.
package branch_resolve_queue_pkg;

  localparam logic [31:0] INSN_W4 = 32'd4;
  localparam logic [31:0] INSN_W2 = 32'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic        compressed;
    logic        pred_taken;
    logic [31:0] pred_target;
  } brq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } brq_state_e;

  // Sequential next PC of a queued instruction, wrapping at 32 bits.
  function automatic logic [31:0] fall_through(input brq_entry_t e);
    return e.pc + (e.compressed ? INSN_W2 : INSN_W4);
  endfunction

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Circular buffer of prediction records with push, pop and a whole-queue flush.
// Flush has priority over a same-cycle push or pop.
module brq_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  brq_entry_t                 i_data,
  output brq_entry_t                 o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  brq_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W:0]     r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predictor lookups; resolves them against execute results,
// drives the predictor update port, redirects fetch and flushes on a mispredict.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PushValid_i,
  input  logic [31:0]       PushPC_i,
  input  logic              PushCompressed_i,
  input  logic              PushPredTaken_i,
  input  logic [31:0]       PushPredTarget_i,
  output logic              PushReady_o,
  input  logic              ResolveValid_i,
  input  logic              ResolveIsBranch_i,
  input  logic              ResolveTaken_i,
  input  logic [31:0]       ResolveTarget_i,
  output logic              ResolveReady_o,
  output logic              miss_o,
  output logic              BranchTaken_o,
  output logic [31:0]       WriteAddr_o,
  output logic [31:0]       WriteTarget_o,
  output logic              Redirect_o,
  output logic [31:0]       RedirectPC_o,
  output logic [CNT_W-1:0]  MissCount_o,
  output logic              ErrUnderflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  brq_state_e      r_state;
  brq_entry_t      w_pushData;
  brq_entry_t      w_head;
  logic [PTR_W:0]  w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_run;
  logic            w_pushFire;
  logic            w_popFire;
  logic            w_actualTaken;
  logic            w_targetDiff;
  logic            w_mispredict;
  logic            w_missFire;
  logic [31:0]     w_cleanTarget;
  logic [31:0]     w_redirectPC;

  assign w_run          = (r_state == RUN);
  assign PushReady_o    = !w_full && w_run;
  assign ResolveReady_o = !w_empty && w_run;
  assign w_pushFire     = PushValid_i && PushReady_o;
  assign w_popFire      = ResolveValid_i && ResolveReady_o;

  assign w_pushData = '{pc: PushPC_i, compressed: PushCompressed_i,
                        pred_taken: PushPredTaken_i, pred_target: PushPredTarget_i};

  // Targets are halfword aligned, so bit 0 never takes part in the compare.
  assign w_cleanTarget = ResolveTarget_i & 32'hFFFF_FFFE;
  assign w_actualTaken = ResolveIsBranch_i && ResolveTaken_i;
  assign w_targetDiff  = w_cleanTarget != (w_head.pred_target & 32'hFFFF_FFFE);

  always_comb begin
    w_mispredict = 1'b0;
    if (ResolveIsBranch_i && ResolveTaken_i)
      w_mispredict = !w_head.pred_taken || w_targetDiff;
    else
      w_mispredict = w_head.pred_taken;
  end

  assign w_missFire   = w_popFire && w_mispredict;
  assign w_redirectPC = w_actualTaken ? w_cleanTarget : fall_through(w_head);

  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_pushFire && !w_missFire),
    .i_pop   (w_popFire),
    .i_flush (w_missFire),
    .i_data  (w_pushData),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= RUN;
    else if (w_missFire)
      r_state <= FLUSH;
    else
      r_state <= RUN;
  end

  // Strobes pulse for one cycle; data outputs hold until the next mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_o         <= 1'b0;
      Redirect_o     <= 1'b0;
      BranchTaken_o  <= 1'b0;
      WriteAddr_o    <= '0;
      WriteTarget_o  <= '0;
      RedirectPC_o   <= '0;
      MissCount_o    <= '0;
      ErrUnderflow_o <= 1'b0;
    end else begin
      miss_o     <= w_missFire;
      Redirect_o <= w_missFire;
      if (w_missFire) begin
        BranchTaken_o <= w_actualTaken;
        WriteAddr_o   <= w_head.pc;
        WriteTarget_o <= w_actualTaken ? w_cleanTarget : 32'h0;
        RedirectPC_o  <= w_redirectPC;
        if (MissCount_o != '1)
          MissCount_o <= MissCount_o + 1'b1;
      end
      if (ResolveValid_i && w_run && w_empty)
        ErrUnderflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized bench for branch_resolve_queue against a queue-based reference model,
// preceded by directed scenarios with literal expectations.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic PushValid_i, PushCompressed_i, PushPredTaken_i;
  logic [31:0] PushPC_i, PushPredTarget_i;
  logic ResolveValid_i, ResolveIsBranch_i, ResolveTaken_i;
  logic [31:0] ResolveTarget_i;
  logic PushReady_o, ResolveReady_o, miss_o, BranchTaken_o, Redirect_o, ErrUnderflow_o;
  logic [31:0] WriteAddr_o, WriteTarget_o, RedirectPC_o;
  logic [CNT_W-1:0] MissCount_o;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .PushValid_i(PushValid_i), .PushPC_i(PushPC_i), .PushCompressed_i(PushCompressed_i),
    .PushPredTaken_i(PushPredTaken_i), .PushPredTarget_i(PushPredTarget_i),
    .PushReady_o(PushReady_o),
    .ResolveValid_i(ResolveValid_i), .ResolveIsBranch_i(ResolveIsBranch_i),
    .ResolveTaken_i(ResolveTaken_i), .ResolveTarget_i(ResolveTarget_i),
    .ResolveReady_o(ResolveReady_o),
    .miss_o(miss_o), .BranchTaken_o(BranchTaken_o), .WriteAddr_o(WriteAddr_o),
    .WriteTarget_o(WriteTarget_o), .Redirect_o(Redirect_o), .RedirectPC_o(RedirectPC_o),
    .MissCount_o(MissCount_o), .ErrUnderflow_o(ErrUnderflow_o)
  );

  typedef struct {
    logic [31:0] pc;
    bit          comp;
    bit          pt;
    logic [31:0] ptgt;
  } rec_t;

  rec_t        mq[$];
  bit          mFlush, mMiss, mBT, mErr;
  logic [31:0] mWA, mWT, mRPC;
  int          mCnt;
  int          checks = 0;
  int          passes = 0;

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: advance one clock edge using the inputs currently applied.
  task automatic modelStep();
    bit run, pushOk, popOk, actT, wrong;
    rec_t h;
    if (rst) begin
      mq.delete(); mFlush = 0; mMiss = 0; mBT = 0; mErr = 0;
      mWA = 0; mWT = 0; mRPC = 0; mCnt = 0;
      return;
    end
    run    = !mFlush;
    mMiss  = 0;
    mFlush = 0;
    pushOk = PushValid_i && run && (mq.size() < DEPTH);
    popOk  = ResolveValid_i && run && (mq.size() > 0);
    if (ResolveValid_i && run && mq.size() == 0) mErr = 1;
    if (popOk) begin
      h     = mq.pop_front();
      actT  = ResolveIsBranch_i && ResolveTaken_i;
      wrong = (actT != h.pt) || (actT && ((ResolveTarget_i >> 1) != (h.ptgt >> 1)));
      if (wrong) begin
        mMiss = 1;
        mBT   = actT;
        mWA   = h.pc;
        mWT   = actT ? {ResolveTarget_i[31:1], 1'b0} : 32'h0;
        mRPC  = actT ? {ResolveTarget_i[31:1], 1'b0} : h.pc + (h.comp ? 32'd2 : 32'd4);
        if (mCnt < (1 << CNT_W) - 1) mCnt++;
        mq.delete();
        mFlush = 1;
        pushOk = 0;
      end
    end
    if (pushOk) mq.push_back('{PushPC_i, PushCompressed_i, PushPredTaken_i, PushPredTarget_i});
  endtask

  task automatic checkOutput();
    checkVal("miss_o", {31'b0, miss_o}, {31'b0, mMiss});
    checkVal("Redirect_o", {31'b0, Redirect_o}, {31'b0, mMiss});
    checkVal("BranchTaken_o", {31'b0, BranchTaken_o}, {31'b0, mBT});
    checkVal("WriteAddr_o", WriteAddr_o, mWA);
    checkVal("WriteTarget_o", WriteTarget_o, mWT);
    checkVal("RedirectPC_o", RedirectPC_o, mRPC);
    checkVal("MissCount_o", 32'(MissCount_o), 32'(mCnt));
    checkVal("ErrUnderflow_o", {31'b0, ErrUnderflow_o}, {31'b0, mErr});
  endtask

  // One clock: readies checked mid-cycle, registered outputs checked 1ns after the edge.
  task automatic applyStimulus();
    @(negedge clk);
    checkVal("PushReady_o", {31'b0, PushReady_o},
             {31'b0, (!mFlush && mq.size() < DEPTH)});
    checkVal("ResolveReady_o", {31'b0, ResolveReady_o},
             {31'b0, (!mFlush && mq.size() > 0)});
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic setIn(input bit pv, input logic [31:0] pc, input bit comp, input bit pt,
                       input logic [31:0] ptgt, input bit rv, input bit rb, input bit rt,
                       input logic [31:0] rtgt);
    PushValid_i = pv; PushPC_i = pc; PushCompressed_i = comp;
    PushPredTaken_i = pt; PushPredTarget_i = ptgt;
    ResolveValid_i = rv; ResolveIsBranch_i = rb; ResolveTaken_i = rt; ResolveTarget_i = rtgt;
    applyStimulus();
  endtask

  task automatic idle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    PushValid_i = 0; PushPC_i = 0; PushCompressed_i = 0; PushPredTaken_i = 0;
    PushPredTarget_i = 0; ResolveValid_i = 0; ResolveIsBranch_i = 0;
    ResolveTaken_i = 0; ResolveTarget_i = 0;
    @(posedge clk);
    modelStep();
    #1;
    rst = 1'b0;
    checkVal("reset PushReady", {31'b0, PushReady_o}, 32'd1);
    checkVal("reset ResolveReady", {31'b0, ResolveReady_o}, 32'd0);
    checkOutput();

    // Not-predicted taken branch
    setIn(1, 32'h100, 0, 0, 32'h0, 0, 0, 0, 0);
    setIn(0, 0, 0, 0, 0, 1, 1, 1, 32'h180);
    checkVal("t1 miss", {31'b0, miss_o}, 32'd1);
    checkVal("t1 BranchTaken", {31'b0, BranchTaken_o}, 32'd1);
    checkVal("t1 WriteAddr", WriteAddr_o, 32'h100);
    checkVal("t1 WriteTarget", WriteTarget_o, 32'h180);
    checkVal("t1 RedirectPC", RedirectPC_o, 32'h180);
    checkVal("t1 MissCount", 32'(MissCount_o), 32'd1);
    checkVal("t1 flush PushReady", {31'b0, PushReady_o}, 32'd0);
    checkVal("t1 model RedirectPC", mRPC, 32'h180);
    idle();

    // Target differing only in bit 0 is a correct prediction
    setIn(1, 32'h200, 0, 1, 32'h240, 0, 0, 0, 0);
    setIn(0, 0, 0, 0, 0, 1, 1, 1, 32'h241);
    checkVal("t2 miss", {31'b0, miss_o}, 32'd0);
    checkVal("t2 MissCount", 32'(MissCount_o), 32'd1);

    // Compressed, predicted taken, actually not taken
    setIn(1, 32'h300, 1, 1, 32'h340, 0, 0, 0, 0);
    setIn(0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    checkVal("t3 miss", {31'b0, miss_o}, 32'd1);
    checkVal("t3 BranchTaken", {31'b0, BranchTaken_o}, 32'd0);
    checkVal("t3 RedirectPC", RedirectPC_o, 32'h302);
    checkVal("t3 WriteAddr", WriteAddr_o, 32'h300);
    checkVal("t3 model RedirectPC", mRPC, 32'h302);
    idle();

    // Fill, overfill, drain, underflow
    for (int i = 0; i < DEPTH; i++) setIn(1, 32'h500 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0);
    checkVal("t4 full PushReady", {31'b0, PushReady_o}, 32'd0);
    setIn(1, 32'h5F0, 0, 1, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) setIn(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkVal("t4 drained ResolveReady", {31'b0, ResolveReady_o}, 32'd0);
    checkVal("t4 no miss", {31'b0, miss_o}, 32'd0);
    setIn(0, 0, 0, 0, 0, 1, 1, 1, 32'h0);
    checkVal("t4 ErrUnderflow", {31'b0, ErrUnderflow_o}, 32'd1);

    // Wrong target flushes younger entries
    setIn(1, 32'h400, 0, 1, 32'h480, 0, 0, 0, 0);
    setIn(1, 32'h404, 0, 0, 32'h0, 0, 0, 0, 0);
    setIn(1, 32'h408, 0, 0, 32'h0, 0, 0, 0, 0);
    setIn(0, 0, 0, 0, 0, 1, 1, 1, 32'h4C0);
    checkVal("t5 miss", {31'b0, miss_o}, 32'd1);
    checkVal("t5 WriteTarget", WriteTarget_o, 32'h4C0);
    idle();
    checkVal("t5 flushed ResolveReady", {31'b0, ResolveReady_o}, 32'd0);

    // Reset wins over a mispredicting resolve at the same edge
    for (int i = 0; i < 3; i++) setIn(1, 32'h600 + 32'(4 * i), 0, 1, 32'h700, 0, 0, 0, 0);
    rst = 1'b1;
    setIn(0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    rst = 1'b0;
    checkVal("t6 miss", {31'b0, miss_o}, 32'd0);
    checkVal("t6 Redirect", {31'b0, Redirect_o}, 32'd0);
    checkVal("t6 MissCount", 32'(MissCount_o), 32'd0);
    checkVal("t6 PushReady", {31'b0, PushReady_o}, 32'd1);
    checkVal("t6 ResolveReady", {31'b0, ResolveReady_o}, 32'd0);

    // Randomized traffic, mostly correct predictions so the queue fills at times
    for (int n = 0; n < 3000; n++) begin
      bit rb, rt, pv, rv;
      logic [31:0] rtgt;
      rec_t h;
      pv   = ($urandom % 10) < 6;
      rv   = ($urandom % 10) < 4;
      rb   = $urandom % 2;
      rt   = $urandom % 2;
      rtgt = $urandom;
      if (mq.size() > 0 && ($urandom % 5) != 0) begin
        h = mq[0];
        if (h.pt) begin
          rb = 1; rt = 1; rtgt = h.ptgt ^ 32'($urandom % 2);
        end else begin
          rt = 0;
        end
      end else if (mq.size() > 0 && ($urandom % 4) == 0) begin
        h = mq[0];
        rtgt = h.pc + (h.comp ? 32'd2 : 32'd4);
      end
      rst = (($urandom % 150) == 0);
      setIn(pv, $urandom, $urandom % 2, $urandom % 2, $urandom, rv, rb, rt, rtgt);
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
